main_mem_responder: RTL and testbench
=====================================

# main_mem_responder

Main-memory responder for the shared cache/TLB memory port. It accepts single-word read and write requests from the CPU's arbitrated `mem_*` bus, which carries i-cache fills, d-cache fills/write-throughs and uncached I/O. It services each request after a fixed, parameterised latency and acknowledges it with a one-cycle `mem_ready` pulse. It sits at the memory end of the port, opposite the cache arbitration mux, and serves as both the synthesizable on-chip memory and the simulation memory.

## Interface
- `AW`, default 12: word-address width; depth is 2^AW 32-bit words.
- `LATENCY`, default 4: cycles from request acceptance to `mem_ready`; legal range 1..255.
- `clk`  in  1  clock.
- `clr`  in  1  reset; synchronous, active-high.
- `mem_a`  in  32  byte address. Word index is `mem_a[AW+1:2]`; other bits are ignored, so addresses alias.
- `mem_access`  in  1  request valid; level, held by the requester until it sees `mem_ready`.
- `mem_write`  in  1  1 = write, 0 = read.
- `mem_st_data`  in  32  write data.
- `mem_data`  out  32  read data, registered; valid while `mem_ready`=1.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_busy`  out  1  state ≠ IDLE.

## Operation
- **States**
  - IDLE, WAIT and DONE.
  - Registers: latched word index `la`, latched write flag `lw`, and down-counter `cnt[7:0]`.
- **IDLE**
  - If `mem_access`=1 at an edge: latch `la`/`lw`, load `cnt`←LATENCY−1, go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT** (priority order at each edge):
  1. `mem_access`=0 → abort and go to IDLE. No array write, no `mem_ready`.
  2. `mem_a` word index ≠ `la` or `mem_write` ≠ `lw` → restart with the new request: relatch, `cnt`←LATENCY−1, stay in WAIT. This covers the requester's arbiter switching from a d-cache miss to an i-cache miss mid-request.
  3. `cnt`=0 → complete:
     - Write: array[`la`]←`mem_st_data` (sampled at this edge).
     - Read: `mem_data`←array[`la`].
     - Then `mem_ready`←1 and go to DONE.
  4. Otherwise `cnt`←`cnt`−1.
- **DONE**
  - `mem_ready`←0, go to IDLE.
  - `mem_access` is ignored at this edge, because the requester is still dropping the old request.
- **Other rules**
  - `mem_data` holds its last read value across writes and idle cycles.
  - Write data changes during WAIT do not restart the request; only the value present at the completion edge is stored.
  - Reset: `mem_ready`=0, `mem_data`=0, `mem_busy`=0, state IDLE, `cnt`=0.
  - Array contents are not reset.
  - Reset asserted mid-request cancels it; a pending write is not performed.

## Timing
- Acceptance edge e0 (IDLE, `mem_access`=1).
  - Completion edge is e0+LATENCY.
  - `mem_ready` is high during the cycle after e0+LATENCY.
  - The requester samples `mem_ready` at e0+LATENCY+1.
- With `mem_access` held continuously (back-to-back requests), the next acceptance edge is e0+LATENCY+2. Ready pulses are therefore LATENCY+2 cycles apart.
- A restart at edge er moves completion to er+LATENCY.
- Read data is registered: `mem_data` and `mem_ready` change on the same edge.
- `mem_ready` is never high for two consecutive cycles.

## Structure
- Shared package `mem_pkg`:
  - state encoding: IDLE=2'd0, WAIT=2'd1, DONE=2'd2;
  - `LAT_W`=8 counter width;
  - word-index extraction constant `WORD_LSB`=2.
- Sub-module `ram_1rw`: 2^AW×32 array with a synchronous write port and an asynchronous read port on `la`. The responder registers the read port output into `mem_data`.
- The FSM, counter and compare logic stay in `main_mem_responder`.
- Elaboration check: fail on LATENCY=0 or LATENCY>255.

## Test plan
1. Reset, then idle 5 cycles → `mem_ready`=0, `mem_data`=0, `mem_busy`=0 every cycle.
2. LATENCY=4: write 0xDEADBEEF to 0x00000010, accepted at e0 → single `mem_ready` pulse after e0+4. Then read 0x00000010 → `mem_data`=0xDEADBEEF with `mem_ready` 4 edges after its acceptance.
3. Read 0x100, then at the second WAIT edge switch `mem_a` to 0x200 (preloaded 0x22222222) → no pulse for 0x100; pulse 4 edges after the switch with `mem_data`=0x22222222.
4. Write 0x55AA55AA to 0x40 (old value 0x11111111), drop `mem_access` after 2 cycles → no `mem_ready`; a later read of 0x40 returns 0x11111111.
5. Hold `mem_access`=1 across three different read addresses, each changed the cycle after `mem_ready` → three pulses spaced exactly LATENCY+2 cycles apart, each with the correct data.
6. LATENCY=1, AW=12:
   - write 0xCAFEF00D at 0x10, read at 0x10|(1<<14) → same data, ready 1 edge after acceptance.
   - Assert `clr` at the completion-minus-one edge of a write → write not performed; outputs return to their reset values.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory responder: FSM encoding, the latency
// counter width and where the word index starts inside a byte address.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int LAT_W    = 8;
    localparam int WORD_LSB = 2;

endpackage

// File: rtl/ram_1rw.sv
// Word-wide storage array: one synchronous write port and an asynchronous read
// port on the same address. Contents are deliberately not reset.
module ram_1rw #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency memory responder for the shared cache/TLB memory port. Completes
// each request LATENCY edges after acceptance with a one-cycle mem_ready pulse.
module main_mem_responder
    import mem_pkg::*;
#(
    parameter int AW      = 12,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] mem_a,
    input  logic        mem_access,
    input  logic        mem_write,
    input  logic [31:0] mem_st_data,
    output logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        mem_busy
);

    generate
        if (LATENCY < 1 || LATENCY > 255) begin : g_latency_check
            $error("main_mem_responder: LATENCY must be in 1..255");
        end
    endgenerate

    localparam logic [LAT_W-1:0] CNT_LOAD = LAT_W'(LATENCY - 1);

    mem_state_t        state_q, state_d;
    logic [AW-1:0]     la_q, la_d;
    logic              lw_q, lw_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              ready_d;
    logic              we;
    logic              rd_load;
    logic [31:0]       data_q;
    logic [31:0]       rdata;
    logic [AW-1:0]     word_idx;
    logic              unused_addr_bits;

    assign word_idx         = mem_a[WORD_LSB+AW-1:WORD_LSB];
    assign unused_addr_bits = ^{mem_a[31:WORD_LSB+AW], mem_a[WORD_LSB-1:0]};

    always_comb begin
        state_d = state_q;
        la_d    = la_q;
        lw_d    = lw_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        we      = 1'b0;
        rd_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_access) begin
                    la_d    = word_idx;
                    lw_d    = mem_write;
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!mem_access) begin
                    state_d = IDLE;
                end else if ((word_idx != la_q) || (mem_write != lw_q)) begin
                    // Arbiter switched requesters mid-flight: restart the wait.
                    la_d  = word_idx;
                    lw_d  = mem_write;
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    we      = lw_q;
                    rd_load = !lw_q;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // Requester is still dropping the old request; ignore mem_access.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            la_q      <= '0;
            lw_q      <= 1'b0;
            cnt_q     <= '0;
            mem_ready <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            la_q      <= la_d;
            lw_q      <= lw_d;
            cnt_q     <= cnt_d;
            mem_ready <= ready_d;
            if (rd_load) begin
                data_q <= rdata;
            end
        end
    end

    // A reset edge must never land a pending write.
    ram_1rw #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (we && !clr),
        .addr  (la_q),
        .wdata (mem_st_data),
        .rdata (rdata)
    );

    assign mem_data = data_q;
    assign mem_busy = (state_q != IDLE);

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: one instance at LATENCY=4 and one at
// LATENCY=1, both AW=12, with a vector table plus hand-written corner sequences.
module tb_main_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // LATENCY=4 instance signals
  logic        clr4, acc4, wr4, ready4, busy4;
  logic [31:0] a4, wd4, data4;
  // LATENCY=1 instance signals
  logic        clr1, acc1, wr1, ready1, busy1;
  logic [31:0] a1, wd1, data1;

  main_mem_responder #(.AW(12), .LATENCY(4)) dut4 (
    .clk(clk), .clr(clr4), .mem_a(a4), .mem_access(acc4), .mem_write(wr4),
    .mem_st_data(wd4), .mem_data(data4), .mem_ready(ready4), .mem_busy(busy4)
  );

  main_mem_responder #(.AW(12), .LATENCY(1)) dut1 (
    .clk(clk), .clr(clr1), .mem_a(a1), .mem_access(acc1), .mem_write(wr1),
    .mem_st_data(wd1), .mem_data(data1), .mem_ready(ready1), .mem_busy(busy1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy(input bit d1);
    return d1 ? ready1 : ready4;
  endfunction

  task automatic drive(input bit d1, input logic acc, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (d1) begin
      acc1 = acc; wr1 = wr; a1 = addr; wd1 = wd;
    end else begin
      acc4 = acc; wr4 = wr; a4 = addr; wd4 = wd;
    end
  endtask

  // Full transaction from a negedge; lat = edges from acceptance to the edge
  // that raised mem_ready, or -1 on timeout.
  task automatic req(input bit d1, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, output int lat, output logic [31:0] data);
    drive(d1, 1'b1, wr, addr, wd);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rdy(d1)) begin
        lat = n - 1;
        break;
      end
    end
    data = d1 ? data1 : data4;
    drive(d1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("ready_one_cycle", {31'b0, rdy(d1)}, 32'h0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          lat;
    logic [31:0] d;
    int          prev;
    int          hits;
    int          found;
    logic [31:0] seq_a[3];
    logic [31:0] seq_d[3];

    // LATENCY=4 table; writes expect mem_data to hold the last read value.
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0200, 32'h2222_2222, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 32'h0000_0040, 32'h1111_1111, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 32'h0000_0100, 32'h0100_0100, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 32'h0000_0200, 32'h0,         32'h2222_2222};
    vecs[6] = '{1'b1, 32'h0000_3FFC, 32'hA5A5_A5A5, 32'h2222_2222};
    vecs[7] = '{1'b0, 32'h0000_3FFC, 32'h0,         32'hA5A5_A5A5};
    vecs[8] = '{1'b0, 32'h0000_4010, 32'h0,         32'hDEAD_BEEF};
    vecs[9] = '{1'b0, 32'hFFFF_0043, 32'h0,         32'h1111_1111};

    clr4 = 1'b1; clr1 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    clr4 = 1'b0; clr1 = 1'b0;

    // Reset state held over idle cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_ready4", {31'b0, ready4}, 32'h0);
      chk("reset_data4",  data4,           32'h0);
      chk("reset_busy4",  {31'b0, busy4},  32'h0);
      chk("reset_ready1", {31'b0, ready1}, 32'h0);
      chk("reset_data1",  data1,           32'h0);
      chk("reset_busy1",  {31'b0, busy1},  32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      req(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, d);
      chk($sformatf("vec%0d_latency", i), lat, 32'd4);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
    end

    // Restart: read 0x100, switch to 0x200 before the second WAIT edge.
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("restart_busy", {31'b0, busy4}, 32'h1);
    a4 = 32'h0000_0200;
    lat = -1;
    hits = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ready4) begin
        lat = n - 1;
        break;
      end
    end
    chk("restart_latency", lat, 32'd4);
    chk("restart_data", data4, 32'h2222_2222);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Abort a write after two cycles: nothing stored, no pulse.
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h55AA_55AA);
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ready4) hits++;
    end
    chk("abort_no_ready", hits, 32'd0);
    chk("abort_idle", {31'b0, busy4}, 32'h0);
    req(1'b0, 1'b0, 32'h0000_0040, 32'h0, lat, d);
    chk("abort_old_value", d, 32'h1111_1111);

    // Back-to-back reads with mem_access held high.
    seq_a[0] = 32'h0000_0010; seq_d[0] = 32'hDEAD_BEEF;
    seq_a[1] = 32'h0000_0200; seq_d[1] = 32'h2222_2222;
    seq_a[2] = 32'h0000_3FFC; seq_d[2] = 32'hA5A5_A5A5;
    prev = -1;
    drive(1'b0, 1'b1, 1'b0, seq_a[0], 32'h0);
    for (int k = 0; k < 3; k++) begin
      found = 0;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (ready4) begin
          found = 1;
          break;
        end
      end
      chk($sformatf("b2b%0d_seen", k), found, 32'd1);
      chk($sformatf("b2b%0d_data", k), data4, seq_d[k]);
      if (k > 0) chk($sformatf("b2b%0d_spacing", k), cyc - prev, 32'd6);
      prev = cyc;
      if (k < 2) a4 = seq_a[k+1];
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Reset during a LATENCY=4 write, one edge before completion.
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h7777_7777);
    repeat (3) @(negedge clk);
    clr4 = 1'b1;
    @(negedge clk);
    chk("clr4_ready", {31'b0, ready4}, 32'h0);
    chk("clr4_busy",  {31'b0, busy4},  32'h0);
    chk("clr4_data",  data4,           32'h0);
    clr4 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    req(1'b0, 1'b0, 32'h0000_0010, 32'h0, lat, d);
    chk("clr4_write_dropped", d, 32'hDEAD_BEEF);

    // LATENCY=1 instance: aliasing and reset cancelling a write.
    req(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, lat, d);
    chk("l1_write_latency", lat, 32'd1);
    req(1'b1, 1'b0, 32'h0000_4010, 32'h0, lat, d);
    chk("l1_read_latency", lat, 32'd1);
    chk("l1_alias_data", d, 32'hCAFE_F00D);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678);
    clr1 = 1'b1;
    @(negedge clk);
    chk("clr1_ready", {31'b0, ready1}, 32'h0);
    chk("clr1_busy",  {31'b0, busy1},  32'h0);
    chk("clr1_data",  data1,           32'h0);
    clr1 = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    req(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, d);
    chk("clr1_write_dropped", d, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
